// File: rtl/pc_trace_pkg.sv
// Shared types and width helpers for the PC trace checker.
package pc_trace_pkg;

  localparam int PC_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_w(input int depth);
    return idx_w(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_trace_checker_if.sv
// Load, trace-sample and status bundle of the PC trace checker.
interface pc_trace_checker_if
  import pc_trace_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int DEPTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                        load_we;
  logic [idx_w(DEPTH)-1:0]     load_addr;
  logic [PC_WIDTH-1:0]         load_data;
  logic [len_w(DEPTH)-1:0]     trace_len;
  logic                        start;
  logic                        pc_valid;
  logic [PC_WIDTH-1:0]         pc;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic                        fail;
  logic                        timed_out;
  logic [idx_w(DEPTH)-1:0]     fail_index;
  logic [PC_WIDTH-1:0]         fail_expected;
  logic [PC_WIDTH-1:0]         fail_actual;
  logic [CNT_WIDTH-1:0]        cycle_count;

  modport master (
    output load_we, load_addr, load_data, trace_len, start, pc_valid, pc,
    input  busy, done, pass, fail, timed_out, fail_index, fail_expected,
           fail_actual, cycle_count
  );

  modport slave (
    input  load_we, load_addr, load_data, trace_len, start, pc_valid, pc,
    output busy, done, pass, fail, timed_out, fail_index, fail_expected,
           fail_actual, cycle_count
  );
endinterface

// File: rtl/pc_trace_table.sv
// Expected-PC table: one synchronous write port, one asynchronous read port, not reset.
module pc_trace_table
  import pc_trace_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH    = 32
) (
  input  logic                    clock,
  input  logic                    we_i,
  input  logic [idx_w(DEPTH)-1:0] waddr_i,
  input  logic [PC_WIDTH-1:0]     wdata_i,
  input  logic [idx_w(DEPTH)-1:0] raddr_i,
  output logic [PC_WIDTH-1:0]     rdata_o
);
  logic [PC_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pc_trace_checker.sv
// Compares fetch-PC samples against a loaded expected trace; sticky pass/fail with capture.
// Optional PC_TRACE_STALL_FILTER_EN drops samples repeating the previous accepted PC.
module pc_trace_checker
  import pc_trace_pkg::*;
#(
  parameter int PC_WIDTH       = PC_WIDTH_DEF,
  parameter int DEPTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic               clock,
  input  logic               reset,
  pc_trace_checker_if.slave  bus
);
  localparam int IW = idx_w(DEPTH);
  localparam int LW = len_w(DEPTH);
  localparam logic [LW-1:0]        DEPTH_L = LW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [LW-1:0]        len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic [IW-1:0]        fidx_q, fidx_d;
  logic [PC_WIDTH-1:0]  fexp_q, fexp_d;
  logic [PC_WIDTH-1:0]  fact_q, fact_d;

  logic [PC_WIDTH-1:0]  exp_pc;
  logic                 take, hit, last_entry;
  logic [CNT_WIDTH-1:0] cnt_inc;

  pc_trace_table #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) u_table (
    .clock   (clock),
    .we_i    (bus.load_we && (state_q != ST_RUN)),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (idx_q),
    .rdata_o (exp_pc)
  );

`ifdef PC_TRACE_STALL_FILTER_EN
  logic [PC_WIDTH-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;

  assign take = bus.pc_valid && !(prev_vld_q && (bus.pc == prev_q));

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (state_q != ST_RUN && bus.start) begin
      prev_vld_d = 1'b0;
    end else if (state_q == ST_RUN && take && hit) begin
      prev_d     = bus.pc;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`else
  assign take = bus.pc_valid;
`endif

  assign hit        = (bus.pc == exp_pc);
  assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      fidx_q  <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      fidx_q  <= fidx_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    fidx_d  = fidx_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;
    if (state_q == ST_RUN) begin
      cnt_d = cnt_inc;
      if (take) begin
        if (!hit) begin
          state_d = ST_FAIL;
          fidx_d  = idx_q;
          fexp_d  = exp_pc;
          fact_d  = bus.pc;
        end else if (last_entry) begin
          state_d = ST_PASS;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      // A final match in the timeout cycle has already moved state_d to PASS.
      if (state_d == ST_RUN && cnt_inc == TO_LAST) begin
        state_d = ST_FAIL;
        to_d    = 1'b1;
        fidx_d  = idx_q;
        fexp_d  = exp_pc;
        fact_d  = '0;
      end
    end else if (bus.start) begin
      idx_d   = '0;
      cnt_d   = '0;
      to_d    = 1'b0;
      fidx_d  = '0;
      fexp_d  = '0;
      fact_d  = '0;
      len_d   = (bus.trace_len > DEPTH_L) ? DEPTH_L : bus.trace_len;
      state_d = (bus.trace_len == '0) ? ST_PASS : ST_RUN;
    end
  end

  always_comb begin
    bus.busy          = (state_q == ST_RUN);
    bus.done          = (state_q == ST_PASS) || (state_q == ST_FAIL);
    bus.pass          = (state_q == ST_PASS);
    bus.fail          = (state_q == ST_FAIL);
    bus.timed_out     = to_q;
    bus.fail_index    = fidx_q;
    bus.fail_expected = fexp_q;
    bus.fail_actual   = fact_q;
    bus.cycle_count   = cnt_q;
  end
endmodule

// File: tb/tb_pc_trace_checker.sv
// Bench for pc_trace_checker: directed trace scenarios plus randomized runs against a trace model.
module tb_pc_trace_checker;
  import pc_trace_pkg::*;

  localparam int PCW   = 64;
  localparam int DEPTH = 8;
  localparam int TO    = 16;
  localparam int CW    = 16;
  localparam int IW    = idx_w(DEPTH);
  localparam int LW    = len_w(DEPTH);

`ifdef PC_TRACE_STALL_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pc_trace_checker_if #(.PC_WIDTH(PCW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus_if ();

  pc_trace_checker #(.PC_WIDTH(PCW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] tab [DEPTH];
  bit          stim_v [$];
  logic [63:0] stim_p [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a, input logic [63:0] d);
    bus_if.load_we   = 1'b1;
    bus_if.load_addr = IW'(a);
    bus_if.load_data = d;
    step();
    bus_if.load_we = 1'b0;
    tab[a] = d;
  endtask

  task automatic start_run(input int len);
    bus_if.trace_len = LW'(len);
    bus_if.start     = 1'b1;
    step();
    bus_if.start = 1'b0;
  endtask

  task automatic feed(input logic [63:0] p);
    bus_if.pc_valid = 1'b1;
    bus_if.pc       = p;
    step();
    bus_if.pc_valid = 1'b0;
  endtask

  task automatic status(input string tag, input bit d, input bit p, input bit f, input bit t);
    check_val({tag, "_done"}, bus_if.done, d);
    check_val({tag, "_pass"}, bus_if.pass, p);
    check_val({tag, "_fail"}, bus_if.fail, f);
    check_val({tag, "_timed_out"}, bus_if.timed_out, t);
    check_val({tag, "_busy"}, bus_if.busy, 1'b0);
  endtask

  // Trace model: walks the sample list in order, one list element per RUN cycle.
  task automatic predict(input int len, output bit e_pass, output bit e_to, output int e_idx,
                         output logic [63:0] e_exp, output logic [63:0] e_act, output int e_cnt);
    int          n;
    int          pos;
    bit          have;
    logic [63:0] last;
    n = (len > DEPTH) ? DEPTH : len;
    e_pass = 1'b0; e_to = 1'b0; e_idx = 0; e_exp = '0; e_act = '0; e_cnt = 0;
    pos = 0; have = 1'b0; last = '0;
    if (n == 0) begin
      e_pass = 1'b1;
      return;
    end
    for (int t = 0; t < 4 * TO; t++) begin
      bit          v;
      logic [63:0] p;
      bit          adv;
      v   = (t < stim_v.size()) ? stim_v[t] : 1'b0;
      p   = (t < stim_p.size()) ? stim_p[t] : 64'd0;
      adv = 1'b0;
      if (v && !(FILT && have && p == last)) begin
        if (p != tab[pos]) begin
          e_idx = pos; e_exp = tab[pos]; e_act = p; e_cnt = t + 1;
          return;
        end
        if (pos == n - 1) begin
          e_pass = 1'b1; e_cnt = t + 1;
          return;
        end
        adv = 1'b1;
      end
      if (t + 1 == TO - 1) begin
        e_to = 1'b1; e_idx = pos; e_exp = tab[pos]; e_act = '0; e_cnt = t + 1;
        return;
      end
      if (adv) begin
        pos++; have = 1'b1; last = p;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          e_pass, e_to;
    int          e_idx, e_cnt, len, n;
    logic [63:0] e_exp, e_act;

    reset = 1'b1;
    bus_if.load_we = 1'b0; bus_if.load_addr = '0; bus_if.load_data = '0;
    bus_if.trace_len = '0; bus_if.start = 1'b0; bus_if.pc_valid = 1'b0; bus_if.pc = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_cnt", bus_if.cycle_count, 0);
    check_val("rst_fidx", bus_if.fail_index, 0);
    check_val("rst_fexp", bus_if.fail_expected, 0);
    check_val("rst_fact", bus_if.fail_actual, 0);

    load(0, 64'h00); load(1, 64'h04); load(2, 64'h08); load(3, 64'h20); load(4, 64'h24);

    // B-type trace
    start_run(5);
    check_val("b_busy", bus_if.busy, 1'b1);
    feed(64'h00); feed(64'h04); feed(64'h08); feed(64'h20); feed(64'h24);
    status("b", 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("b_cnt", bus_if.cycle_count, 5);

    // Mismatch at entry 3
    start_run(5);
    feed(64'h00); feed(64'h04); feed(64'h08); feed(64'h0C);
    status("mm", 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("mm_fidx", bus_if.fail_index, 3);
    check_val("mm_fexp", bus_if.fail_expected, 64'h20);
    check_val("mm_fact", bus_if.fail_actual, 64'h0C);

    // Restart after fail
    start_run(5);
    check_val("rs_busy", bus_if.busy, 1'b1);
    check_val("rs_fail", bus_if.fail, 1'b0);
    check_val("rs_fact", bus_if.fail_actual, 0);
    check_val("rs_cnt", bus_if.cycle_count, 0);
    feed(64'h00); feed(64'h04); feed(64'h08); feed(64'h20); feed(64'h24);
    status("rs", 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("rs_cnt2", bus_if.cycle_count, 5);

    // Timeout with two valid samples
    start_run(5);
    feed(64'h00); feed(64'h04);
    repeat (20) step();
    status("to", 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("to_fidx", bus_if.fail_index, 2);
    check_val("to_fexp", bus_if.fail_expected, 64'h08);
    check_val("to_fact", bus_if.fail_actual, 0);
    check_val("to_cnt", bus_if.cycle_count, 15);

    // Zero-length trace
    start_run(0);
    status("z", 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("z_cnt", bus_if.cycle_count, 0);

    // Table write during RUN is ignored
    start_run(5);
    bus_if.load_we = 1'b1; bus_if.load_addr = IW'(2); bus_if.load_data = 64'hDEAD;
    feed(64'h00);
    bus_if.load_we = 1'b0;
    feed(64'h04); feed(64'h08); feed(64'h20); feed(64'h24);
    status("lr", 1'b1, 1'b1, 1'b0, 1'b0);

    // Write together with start: the run sees the new value
    bus_if.load_we = 1'b1; bus_if.load_addr = '0; bus_if.load_data = 64'h100;
    tab[0] = 64'h100;
    start_run(5);
    bus_if.load_we = 1'b0;
    feed(64'h100); feed(64'h04); feed(64'h08); feed(64'h20); feed(64'h24);
    status("ls", 1'b1, 1'b1, 1'b0, 1'b0);
    load(0, 64'h00);

    // Stalled repeat PC
    start_run(5);
    feed(64'h00); feed(64'h04); feed(64'h04); feed(64'h08); feed(64'h20); feed(64'h24);
    if (FILT) begin
      status("st", 1'b1, 1'b1, 1'b0, 1'b0);
    end else begin
      status("st", 1'b1, 1'b0, 1'b1, 1'b0);
      check_val("st_fidx", bus_if.fail_index, 2);
      check_val("st_fexp", bus_if.fail_expected, 64'h08);
      check_val("st_fact", bus_if.fail_actual, 64'h04);
    end

    // trace_len above DEPTH clamps
    load(5, 64'h28); load(6, 64'h2C); load(7, 64'h30);
    start_run(DEPTH + 3);
    for (int i = 0; i < DEPTH; i++) feed(tab[i]);
    status("cl", 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("cl_cnt", bus_if.cycle_count, DEPTH);

    // Asynchronous reset mid-run
    start_run(5);
    feed(64'h00); feed(64'h04);
    #2 reset = 1'b1;
    #1;
    status("ar", 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("ar_cnt", bus_if.cycle_count, 0);
    check_val("ar_fidx", bus_if.fail_index, 0);
    #2 reset = 1'b0;
    step();
    start_run(5);
    feed(64'h00); feed(64'h04); feed(64'h08); feed(64'h20); feed(64'h24);
    status("ar2", 1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      if (r % 3 == 0) begin
        for (int a = 0; a < DEPTH; a++) load(a, {$urandom, $urandom});
      end
      len = $urandom_range(0, DEPTH + 2);
      n   = (len > DEPTH) ? DEPTH : len;
      stim_v.delete(); stim_p.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          int g;
          g = $urandom_range(1, 2);
          for (int j = 0; j < g; j++) begin
            stim_v.push_back(1'b0); stim_p.push_back({$urandom, $urandom});
          end
        end
        if (k > 0 && $urandom_range(0, 9) == 0) begin
          stim_v.push_back(1'b1); stim_p.push_back(tab[k-1]);
        end
        stim_v.push_back(1'b1);
        stim_p.push_back(($urandom_range(0, 19) == 0) ? {$urandom, $urandom} : tab[k]);
      end
      predict(len, e_pass, e_to, e_idx, e_exp, e_act, e_cnt);
      start_run(len);
      for (int t = 0; t < stim_v.size(); t++) begin
        bus_if.pc_valid = stim_v[t];
        bus_if.pc       = stim_p[t];
        step();
      end
      bus_if.pc_valid = 1'b0;
      repeat (TO + 2) step();
      status($sformatf("rnd%0d", r), 1'b1, e_pass, !e_pass, e_to);
      check_val($sformatf("rnd%0d_cnt", r), bus_if.cycle_count, e_cnt);
      if (!e_pass) begin
        check_val($sformatf("rnd%0d_fidx", r), bus_if.fail_index, 64'(e_idx));
        check_val($sformatf("rnd%0d_fexp", r), bus_if.fail_expected, e_exp);
        check_val($sformatf("rnd%0d_fact", r), bus_if.fail_actual, e_act);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_trace_checker.md
Name: pc_trace_checker

Overview:
- Self-checking program-counter trace monitor for the PipelinedARMv8 instruction-class benches (B, CB, R, D type).
- Holds a loadable table of expected fetch-PC values, up to DEPTH entries.
- Compares each valid PC sample from instruction fetch against the table in order.
- Reports pass/fail, the first mismatch and a cycle count, replacing manual $monitor inspection of branch behaviour.

Parameters:
- PC_WIDTH, 64, width of the PC and of the expected-table entries
- DEPTH, 32, number of expected-trace entries (power of two)
- TIMEOUT_CYCLES, 1024, RUN cycles allowed before a timeout fail
- CNT_WIDTH, 16, width of the cycle counter

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- load_we  input  1  write an expected entry
- load_addr  input  $clog2(DEPTH)  table index to write
- load_data  input  PC_WIDTH  expected PC value
- trace_len  input  $clog2(DEPTH)+1  number of entries to check; sampled on start
- start  input  1  begin a check run
- pc_valid  input  1  pc carries a valid fetch sample this cycle
- pc  input  PC_WIDTH  fetch-stage PC
- busy  output  1  state is RUN
- done  output  1  run finished (pass or fail), sticky
- pass  output  1  all entries matched, sticky
- fail  output  1  mismatch or timeout, sticky
- timed_out  output  1  fail was caused by timeout
- fail_index  output  $clog2(DEPTH)  index of the failing entry
- fail_expected  output  PC_WIDTH  expected PC at the failure
- fail_actual  output  PC_WIDTH  sampled PC at the failure; 0 on timeout
- cycle_count  output  CNT_WIDTH  RUN cycles elapsed

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs and internal counters = 0.
  - Table contents are not reset.
- State IDLE:
  - load_we writes table[load_addr] = load_data on the clock edge.
  - start with trace_len==0 → PASS immediately (done=pass=1 next cycle).
  - start with trace_len>0 → RUN; index=0, cycle_count=0, all status cleared, trace_len latched.
- State RUN:
  - busy=1.
  - cycle_count increments each cycle and saturates at all-ones.
  - On pc_valid, pc is compared with table[index]:
    - Match, index < len-1 → index++.
    - Match, index == len-1 → PASS.
    - Mismatch → FAIL; fail_index=index, fail_expected=table[index], fail_actual=pc.
  - No pc_valid → index holds.
  - cycle_count reaching TIMEOUT_CYCLES-1 without completion → FAIL; timed_out=1, fail_index=index, fail_expected=table[index], fail_actual=0.
  - Final match and timeout in the same cycle → PASS wins.
- States PASS / FAIL:
  - Sticky; done=1; cycle_count frozen.
  - start → RUN with a fresh run (status cleared), same rules as IDLE.
- Simultaneous events:
  - load_we during RUN is ignored (table frozen).
  - load_we together with start in IDLE/PASS/FAIL: the write happens; the run reads the new value.
  - start while in RUN is ignored.
- Latency: status outputs are registered and valid on the edge after the deciding sample. The comparison is combinational from the table read, with no extra pipeline stage.
- trace_len > DEPTH is clamped to DEPTH.

Optional Feature:
- Macro: PC_TRACE_STALL_FILTER_EN.
- Defined:
  - A pc_valid sample equal to the previous accepted sample is discarded, so pipeline stalls holding the PC are not compared.
  - The first sample of a run is always compared.
  - Filter history is cleared on start and reset.
- Undefined: every pc_valid sample is compared; a stalled repeat PC produces a mismatch.

Decomposition:
- Shared package pc_trace_pkg holds:
  - the state enum (IDLE, RUN, PASS, FAIL),
  - the PC_WIDTH default,
  - localparam functions for the index width.
- One sub-module, pc_trace_table: DEPTH×PC_WIDTH register array with a single write port and an asynchronous read port.
- The FSM, counters and failure capture stay in the top module.

Test Plan:
- B-type trace:
  - Stimulus: load 0x00,0x04,0x08,0x20,0x24 (B #24 from 0x08), trace_len=5, start, feed that PC sequence with pc_valid.
  - Response: pass=1, done=1, fail=0, cycle_count=5 one cycle after the last sample.
- Mismatch:
  - Stimulus: same table, feed 0x00,0x04,0x08,0x0C.
  - Response: fail=1, fail_index=3, fail_expected=0x20, fail_actual=0x0C, timed_out=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, trace_len=5, only two valid samples.
  - Response: fail=1, timed_out=1, fail_index=2, cycle_count=15.
- Edge cases:
  - trace_len=0 with start → pass=1 next cycle.
  - load_we during RUN does not alter table entry 2 (verified by a subsequent pass).
  - Asynchronous reset mid-RUN → all outputs 0 without waiting for a clock edge.
- Stall filter:
  - Stimulus: feed 0x00,0x04,0x04,0x08,0x20,0x24.
  - With PC_TRACE_STALL_FILTER_EN: pass=1.
  - Without it: fail=1, fail_index=2, fail_actual=0x04.
- Restart:
  - Stimulus: after a FAIL, start again and feed the correct trace.
  - Response: status cleared on the start edge, then pass=1; cycle_count restarts from 0.
